// File: rtl/sms_bk_pkg.sv
// Shared types and constants for the save-RAM backup controller.
//   bk_state_t      : controller state (IDLE / ISSUE / XFER / LAST)
//   bk_dir_t        : transfer direction (load from SD / save to SD)
//   SECT_BYTES_LOG2 : log2 of the SD sector size in bytes
package sms_bk_pkg;

  localparam int SECT_BYTES_LOG2 = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_XFER  = 2'd2,
    ST_LAST  = 2'd3
  } bk_state_t;

  typedef enum logic {
    DIR_LOAD = 1'b0,
    DIR_SAVE = 1'b1
  } bk_dir_t;

endpackage

// File: rtl/sms_bk_ctrl_edge_det.sv
// Single-bit edge detector: remembers the previous sample and flags
// rising/falling transitions of the current input against it.
//   clk_sys : system clock
//   reset   : synchronous active-high clear of the history
//   din     : input level to watch
//   rise    : din high now, low last cycle
//   fall    : din low now, high last cycle
module edge_det (
  input  logic clk_sys,
  input  logic reset,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic prev_reg;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      prev_reg <= 1'b0;
    end else begin
      prev_reg <= din;
    end
  end

  assign rise = din & ~prev_reg;
  assign fall = ~din & prev_reg;

endmodule

// File: rtl/sms_bk_ctrl.sv
// Save-RAM backup controller. Loads the mounted .SAV image into NVRAM
// port B on mount, writes NVRAM back to the image on a save request,
// tracks NVRAM modification and pulses a core reset after a load.
//   clk_sys, reset          : clock, synchronous active-high reset
//   img_mounted, img_size   : mount strobe and image size from user_io
//   save_req                : save request level (rising edge triggers)
//   nvram_we                : core-side NVRAM write strobe (dirty tracking)
//   sd_ack, sd_buff_addr,
//   sd_buff_wr              : SD sector handshake and byte stream
//   sd_lba, sd_rd, sd_wr    : sector request to user_io
//   buf_addr, buf_we        : NVRAM port-B address / write enable
//   bk_ena, bk_busy,
//   bk_dirty, bk_reset      : status and core-reset pulse
module sms_bk_ctrl
  import sms_bk_pkg::*;
#(
  parameter int SECT_LOG2 = 4
) (
  input  logic                                clk_sys,
  input  logic                                reset,
  input  logic                                img_mounted,
  input  logic [31:0]                         img_size,
  input  logic                                save_req,
  input  logic                                nvram_we,
  input  logic                                sd_ack,
  input  logic [SECT_BYTES_LOG2-1:0]          sd_buff_addr,
  input  logic                                sd_buff_wr,
  output logic [31:0]                         sd_lba,
  output logic                                sd_rd,
  output logic                                sd_wr,
  output logic [SECT_LOG2+SECT_BYTES_LOG2-1:0] buf_addr,
  output logic                                buf_we,
  output logic                                bk_ena,
  output logic                                bk_busy,
  output logic                                bk_dirty,
  output logic                                bk_reset
);

  // Edge detectors: bit 0 img_mounted, bit 1 save_req, bit 2 sd_ack.
  logic [2:0] edge_in;
  logic [2:0] edge_rise;
  logic [2:0] edge_fall;

  assign edge_in = {sd_ack, save_req, img_mounted};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_edge
      edge_det u_edge (
        .clk_sys (clk_sys),
        .reset   (reset),
        .din     (edge_in[gi]),
        .rise    (edge_rise[gi]),
        .fall    (edge_fall[gi])
      );
    end
  endgenerate

  logic mount_rise, save_rise, ack_rise, ack_fall;
  logic unused_fall;

  assign mount_rise  = edge_rise[0];
  assign save_rise   = edge_rise[1];
  assign ack_rise    = edge_rise[2];
  assign ack_fall    = edge_fall[2];
  assign unused_fall = |edge_fall[1:0];

  bk_state_t   state_reg, state_next;
  bk_dir_t     dir_reg, dir_next;
  logic [31:0] sd_lba_reg, sd_lba_next;
  logic        sd_rd_reg, sd_rd_next;
  logic        sd_wr_reg, sd_wr_next;
  logic        load_pend_reg, load_pend_next;
  logic        save_pend_reg, save_pend_next;
  logic        bk_ena_reg, bk_ena_next;
  logic        bk_dirty_reg, bk_dirty_next;
  logic        bk_reset_reg, bk_reset_next;

  // State register
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      dir_reg       <= DIR_LOAD;
      sd_lba_reg    <= '0;
      sd_rd_reg     <= 1'b0;
      sd_wr_reg     <= 1'b0;
      load_pend_reg <= 1'b0;
      save_pend_reg <= 1'b0;
      bk_ena_reg    <= 1'b0;
      bk_dirty_reg  <= 1'b0;
      bk_reset_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      dir_reg       <= dir_next;
      sd_lba_reg    <= sd_lba_next;
      sd_rd_reg     <= sd_rd_next;
      sd_wr_reg     <= sd_wr_next;
      load_pend_reg <= load_pend_next;
      save_pend_reg <= save_pend_next;
      bk_ena_reg    <= bk_ena_next;
      bk_dirty_reg  <= bk_dirty_next;
      bk_reset_reg  <= bk_reset_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next     = state_reg;
    dir_next       = dir_reg;
    sd_lba_next    = sd_lba_reg;
    sd_rd_next     = sd_rd_reg;
    sd_wr_next     = sd_wr_reg;
    load_pend_next = load_pend_reg;
    save_pend_next = save_pend_reg;
    bk_ena_next    = bk_ena_reg;
    bk_dirty_next  = bk_dirty_reg;
    bk_reset_next  = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (load_pend_reg) begin
          dir_next       = DIR_LOAD;
          sd_lba_next    = '0;
          sd_rd_next     = 1'b1;
          load_pend_next = 1'b0;
          state_next     = ST_ISSUE;
        end else if (save_pend_reg) begin
          dir_next       = DIR_SAVE;
          sd_lba_next    = '0;
          sd_wr_next     = 1'b1;
          save_pend_next = 1'b0;
          bk_dirty_next  = 1'b0;
          state_next     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (ack_rise) begin
          sd_rd_next = 1'b0;
          sd_wr_next = 1'b0;
          state_next = ST_XFER;
        end
      end
      ST_XFER: begin
        if (ack_fall) begin
          if (&sd_lba_reg[SECT_LOG2-1:0]) begin
            state_next = ST_LAST;
          end else begin
            // Upper LBA bits never move: the increment stops at the last sector.
            sd_lba_next = sd_lba_reg + 32'd1;
            sd_rd_next  = (dir_reg == DIR_LOAD);
            sd_wr_next  = (dir_reg == DIR_SAVE);
            state_next  = ST_ISSUE;
          end
        end
      end
      ST_LAST: begin
        if (dir_reg == DIR_LOAD) begin
          bk_reset_next = 1'b1;
          bk_dirty_next = 1'b0;
        end
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase

    // Request latching is applied after the IDLE consume so a new edge in the
    // same cycle is never lost. Save is evaluated before mount so that an
    // empty mount in the same cycle still cancels it.
    if (save_rise && bk_ena_reg) begin
      save_pend_next = 1'b1;
    end
    if (mount_rise) begin
      if (img_size != 32'd0) begin
        bk_ena_next    = 1'b1;
        load_pend_next = 1'b1;
      end else begin
        bk_ena_next    = 1'b0;
        load_pend_next = 1'b0;
        save_pend_next = 1'b0;
      end
    end

    // Core writes win over any clear in the same cycle.
    if (nvram_we) begin
      bk_dirty_next = 1'b1;
    end
  end

  // Output logic
  always_comb begin
    buf_we  = sd_buff_wr & sd_ack & (dir_reg == DIR_LOAD) & (state_reg == ST_XFER);
    bk_busy = (state_reg != ST_IDLE);
  end

  assign buf_addr = {sd_lba_reg[SECT_LOG2-1:0], sd_buff_addr};
  assign sd_lba   = sd_lba_reg;
  assign sd_rd    = sd_rd_reg;
  assign sd_wr    = sd_wr_reg;
  assign bk_ena   = bk_ena_reg;
  assign bk_dirty = bk_dirty_reg;
  assign bk_reset = bk_reset_reg;

endmodule

// File: tb/tb_sms_bk_ctrl.sv
// Self-checking bench for sms_bk_ctrl: an SD sector model drives randomized
// byte streams and handshake gaps; expectations come from a small
// behavioural model of the enable / pending-save / dirty flags and from
// address arithmetic (lba*512 + byte).
module tb_sms_bk_ctrl;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        img_mounted = 1'b0;
  logic [31:0] img_size = '0;
  logic        save_req = 1'b0;
  logic        nvram_we = 1'b0;
  logic        sd_ack = 1'b0;
  logic [8:0]  sd_buff_addr = '0;
  logic        sd_buff_wr = 1'b0;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr;
  logic [12:0] buf_addr;
  logic        buf_we, bk_ena, bk_busy, bk_dirty, bk_reset;

  sms_bk_ctrl #(.SECT_LOG2(4)) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .img_mounted  (img_mounted),
    .img_size     (img_size),
    .save_req     (save_req),
    .nvram_we     (nvram_we),
    .sd_ack       (sd_ack),
    .sd_buff_addr (sd_buff_addr),
    .sd_buff_wr   (sd_buff_wr),
    .sd_lba       (sd_lba),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .buf_addr     (buf_addr),
    .buf_we       (buf_we),
    .bk_ena       (bk_ena),
    .bk_busy      (bk_busy),
    .bk_dirty     (bk_dirty),
    .bk_reset     (bk_reset)
  );

  always #5 clk_sys = ~clk_sys;

  int total = 0;
  int bad = 0;

  // Behavioural model state
  bit m_ena = 0;
  bit m_save_pend = 0;
  bit m_dirty = 0;

  // Passive counters sampled on the falling edge
  int we_cnt = 0;
  int rst_pulses = 0;
  int req_seen = 0;
  bit cov [8192];

  always @(negedge clk_sys) begin
    if (buf_we) begin
      we_cnt++;
      cov[buf_addr] = 1'b1;
    end
    if (bk_reset) rst_pulses++;
    if (sd_rd | sd_wr) req_seen++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd"},    sd_rd, 0);
    chk({tag, "_wr"},    sd_wr, 0);
    chk({tag, "_lba"},   sd_lba, 0);
    chk({tag, "_busy"},  bk_busy, 0);
    chk({tag, "_ena"},   bk_ena, 0);
    chk({tag, "_dirty"}, bk_dirty, 0);
    chk({tag, "_rst"},   bk_reset, 0);
    chk({tag, "_we"},    buf_we, 0);
  endtask

  // Mount and check the N / N+1 registration timing.
  task automatic mount(input logic [31:0] sz);
    img_mounted = 1'b1;
    img_size    = sz;
    tick();
    img_mounted = 1'b0;
    img_size    = $urandom;
    m_ena = (sz != 0);
    if (sz == 0) m_save_pend = 0;
    $display("mount size=%0d", sz);
    chk("mnt_ena", bk_ena, m_ena);
    chk("mnt_rd_early", sd_rd, 0);
    tick();
    chk("mnt_rd", sd_rd, m_ena);
    if (m_ena) chk("mnt_lba", sd_lba, 0);
  endtask

  task automatic dirty_pulse();
    nvram_we = 1'b1;
    tick();
    nvram_we = 1'b0;
    m_dirty = 1;
    chk("dirty_set", bk_dirty, 1);
  endtask

  // Serve all 16 sectors of one transfer. Entry: first request is visible.
  task automatic run_xfer(input bit is_load, input int save_at, input int rst_at);
    int  addr;
    bit  wr;
    int  n0;
    for (int s = 0; s < 16; s++) begin
      chk("req_lba", sd_lba, s);
      chk("req_rd", sd_rd, is_load);
      chk("req_wr", sd_wr, !is_load);
      chk("req_busy", bk_busy, 1);
      repeat ($urandom_range(0, 2)) begin
        tick();
        chk("req_hold", sd_rd | sd_wr, 1);
      end
      sd_ack = 1'b1;
      tick();
      chk("ack_drop", sd_rd | sd_wr, 0);
      addr = 0;
      while (addr < 512) begin
        wr = is_load ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 3) == 0);
        sd_buff_addr = addr[8:0];
        sd_buff_wr   = wr;
        if (s == save_at && addr == 100) begin
          save_req = 1'b1;
          if (m_ena) m_save_pend = 1;
        end
        if (s == save_at && addr == 200) save_req = 1'b0;
        if (s == rst_at && addr == 256) begin
          sd_buff_wr = 1'b1;
          reset = 1'b1;
          tick();
          reset = 1'b0;
          m_ena = 0; m_dirty = 0; m_save_pend = 0;
          $display("reset mid-transfer lba=%0d", s);
          chk_all_zero("midrst");
          n0 = req_seen;
          repeat (3) tick();
          sd_ack = 1'b0;
          sd_buff_wr = 1'b0;
          repeat (10) tick();
          chk("no_retry", req_seen - n0, 0);
          chk("no_retry_busy", bk_busy, 0);
          return;
        end
        #1;
        chk("buf_we", buf_we, is_load & wr);
        if (is_load & wr) chk("buf_addr", buf_addr, s * 512 + addr);
        if (wr || !is_load) addr++;
        tick();
      end
      sd_buff_wr = 1'b0;
      sd_ack     = 1'b0;
      tick();
      $display("sector %s lba=%0d", is_load ? "load" : "save", s);
    end
    chk("last_busy", bk_busy, 1);
    chk("last_rst", bk_reset, 0);
    tick();
    if (is_load) m_dirty = 0;
    chk("bk_reset", bk_reset, is_load);
    chk("idle_busy", bk_busy, 0);
    chk("end_dirty", bk_dirty, m_dirty);
    tick();
    chk("rst_width", bk_reset, 0);
    chk("chain_wr", sd_wr, m_save_pend);
    chk("chain_rd", sd_rd, 0);
    if (m_save_pend) begin
      chk("chain_lba", sd_lba, 0);
      m_save_pend = 0;
      chk("chain_dirty", bk_dirty, m_dirty);
    end
  endtask

  // Save edge from idle; optionally collide a core write with the start.
  task automatic save_from_idle(input bit collide);
    save_req = 1'b1;
    tick();
    save_req = 1'b0;
    if (m_ena) m_save_pend = 1;
    nvram_we = collide;
    tick();
    nvram_we = 1'b0;
    if (m_save_pend) begin
      m_save_pend = 0;
      m_dirty = collide;
      chk("save_start_wr", sd_wr, 1);
      chk("save_start_lba", sd_lba, 0);
      chk("save_start_dirty", bk_dirty, m_dirty);
    end
  endtask

  int we0, rp0, rq0, covn;

  initial begin
    repeat (3) tick();
    chk_all_zero("reset");
    reset = 1'b0;
    tick();
    chk_all_zero("post_reset");

    // Full load
    for (int i = 0; i < 8192; i++) cov[i] = 1'b0;
    we0 = we_cnt; rp0 = rst_pulses;
    mount(32'd8192);
    run_xfer(1'b1, -1, -1);
    covn = 0;
    for (int i = 0; i < 8192; i++) covn += int'(cov[i]);
    chk("load_we_cnt", we_cnt - we0, 8192);
    chk("load_cover", covn, 8192);
    chk("load_rst_pulses", rst_pulses - rp0, 1);
    chk("load_dirty", bk_dirty, 0);

    // Dirty then save
    dirty_pulse();
    rp0 = rst_pulses; we0 = we_cnt;
    save_from_idle(1'b0);
    run_xfer(1'b0, -1, -1);
    chk("save_no_we", we_cnt - we0, 0);
    chk("save_no_rst", rst_pulses - rp0, 0);

    // Core write colliding with save-start clear
    save_from_idle(1'b1);
    run_xfer(1'b0, -1, -1);
    chk("prio_dirty_kept", bk_dirty, 1);

    // Save edge during sector 5 of a load
    rp0 = rst_pulses;
    mount(32'd8192);
    run_xfer(1'b1, 5, -1);
    chk("sdl_rst_pulses", rst_pulses - rp0, 1);
    run_xfer(1'b0, -1, -1);

    // Zero-size mount disables everything
    rq0 = req_seen;
    mount(32'd0);
    save_from_idle(1'b0);
    repeat (30) tick();
    chk("zero_ena", bk_ena, 0);
    chk("zero_no_req", req_seen - rq0, 0);
    chk("zero_busy", bk_busy, 0);

    // Reset in the middle of sector 7 of a load
    dirty_pulse();
    mount($urandom_range(1, 32'h0010_0000));
    run_xfer(1'b1, -1, 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #2_000_000;
    bad++;
    $display("FAIL timeout: got=running exp=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
